// File: rtl/uart_cfg.sv
// Parametrised UART: TX with exact start-bit phase, RX with 16x oversampling,
// parity/framing checks and a small receive FIFO with sticky overrun.
module uart_cfg #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TX_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int RX_DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int TCW    = $clog2(TX_DIV + 1);
  localparam int RCW    = $clog2(RX_DIV + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = DATA_BITS + 2;

  localparam logic [TCW-1:0] TX_LAST  = TCW'(TX_DIV - 1);
  localparam logic [RCW-1:0] RX_LAST  = RCW'(RX_DIV - 1);
  localparam logic [2:0]     DLAST    = 3'(DATA_BITS - 1);
  localparam logic           SLAST    = (STOP_BITS == 2);
  localparam logic           ODD      = (PARITY == 1);
  localparam logic           HAS_PAR  = (PARITY != 0);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                tx_state, tx_state_n;
  logic [TCW-1:0]        tx_cnt;
  logic [2:0]            tx_bit;
  logic                  tx_stop;
  logic [DATA_BITS-1:0]  tx_shift;
  logic                  tx_par;
  logic                  tx_tick;
  logic                  tx_load;

  assign tx_tick = (tx_cnt == TX_LAST);
  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk_50m) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_load    = 1'b0;
    tx         = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (wr_en) begin
          tx_load    = 1'b1;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tx_tick) tx_state_n = S_DATA;
      end
      S_DATA: begin
        tx = tx_shift[0];
        if (tx_tick && tx_bit == DLAST) tx_state_n = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx = tx_par;
        if (tx_tick) tx_state_n = S_STOP;
      end
      S_STOP: begin
        if (tx_tick && tx_stop == SLAST) tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // The bit timer is cleared on accept so the start bit always lasts a full TX_DIV.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_load) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= din;
      tx_par   <= (^din) ^ ODD;
    end else if (tx_state != S_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_state == S_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 3'd1;
        end
        if (tx_state == S_STOP) tx_stop <= ~tx_stop;
      end else begin
        tx_cnt <= tx_cnt + TCW'(1);
      end
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_s1, rx_s2, rx_prev;
  state_t               rx_state, rx_state_n;
  logic [RCW-1:0]       rx_div;
  logic [3:0]           rx_os;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 os_tick, rx_sample, rx_bit_end, rx_start, push;

  assign os_tick    = (rx_div == RX_LAST);
  assign rx_sample  = os_tick && (rx_os == 4'd7);
  assign rx_bit_end = os_tick && (rx_os == 4'd15);
  assign rx_start   = rx_prev & ~rx_s2;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    push       = 1'b0;
    case (rx_state)
      S_IDLE:   if (rx_start) rx_state_n = S_START;
      S_START: begin
        if (rx_sample && rx_s2) rx_state_n = S_IDLE;
        else if (rx_bit_end)    rx_state_n = S_DATA;
      end
      S_DATA:   if (rx_bit_end && rx_bit == DLAST) rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (rx_bit_end) rx_state_n = S_STOP;
      S_STOP: begin
        if (rx_sample) begin
          push       = 1'b1;
          rx_state_n = S_IDLE;
        end
      end
      default:  rx_state_n = S_IDLE;
    endcase
  end

  // Counters sit at zero while idle, so tick 0 lines up with the detected edge.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_div   <= '0;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      rx_div  <= '0;
      rx_os   <= '0;
      rx_bit  <= '0;
      rx_perr <= 1'b0;
    end else begin
      rx_div <= os_tick ? '0 : rx_div + RCW'(1);
      if (os_tick) rx_os <= rx_os + 4'd1;
      if (rx_sample && rx_state == S_DATA)   rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
      if (rx_sample && rx_state == S_PARITY) rx_perr  <= (^rx_shift) ^ rx_s2 ^ ODD;
      if (rx_bit_end && rx_state == S_DATA)  rx_bit   <= rx_bit + 3'd1;
    end
  end

  // ---------------- receive FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic [EW-1:0] head;
  logic          empty, full, pop, push_ok;

  assign empty   = (wp == rp);
  assign full    = ((wp - rp) == FULL_CNT);
  assign pop     = rdy_clr & ~empty;
  assign push_ok = push & (~full | pop);
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + (AW + 1)'(1);
      if (pop)     rp <= rp + (AW + 1)'(1);
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (push_ok) mem[wp[AW-1:0]] <= {rx_shift, rx_perr, ~rx_s2};
  end

  // Storage is not reset, so the head is masked until something is queued.
  assign rdy        = ~empty;
  assign dout       = rdy ? head[EW-1:2] : '0;
  assign parity_err = rdy & head[1];
  assign frame_err  = rdy & head[0];

endmodule
